// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable clock divider.
// Produces a registered divided clock (LO cycles low, then HI cycles high per
// period), a one-cycle tick in the last cycle of each period, and a shadowed
// configuration interface. A new setting is validated on load, held pending,
// and only takes effect at a period boundary (or at once while idle), so the
// output never glitches mid-period.
module freq_div_prog #(
  parameter int unsigned      WIDTH   = 26,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(49_999_999),
  parameter logic [WIDTH-1:0] DEF_HI  = WIDTH'(25_000_000)
) (
  input  logic             clk_50MHz,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_hi,
  output logic             clk_out,
  output logic             tick,
  output logic             upd_ack,
  output logic             cfg_err,
  output logic             busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Period counter and active (in-use) configuration
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic [WIDTH-1:0] act_hi_q, act_hi_d;

  // Shadow configuration waiting for the next boundary
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic             pend_q, pend_d;

  // Registered outputs
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             upd_ack_q, upd_ack_d;
  logic             cfg_err_q, cfg_err_d;

  // Decoded control
  logic             boundary;
  logic             apply;
  logic             load_ok;
  logic [WIDTH:0]   cfg_div_p1;
  logic [WIDTH:0]   lo_d;

  // Period boundary is the last cycle of a running period; pending settings
  // are taken here, or on any idle cycle since idle has no period to protect.
  always_comb begin
    boundary   = (state_q == ST_RUN) && (count_q == act_div_q);
    apply      = pend_q && ((state_q == ST_IDLE) || boundary);
    cfg_div_p1 = {1'b0, cfg_div} + (WIDTH+1)'(1);
    load_ok    = load && (cfg_div != '0) && ({1'b0, cfg_hi} <= cfg_div_p1);
  end

  // Run/idle state register
  always_ff @(posedge clk_50MHz or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the run enable, one cycle later
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)  state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration path: boundary apply first, then the new load, so a load
  // landing on a boundary becomes the next pending value instead of racing it
  always_comb begin
    act_div_d  = act_div_q;
    act_hi_d   = act_hi_q;
    pend_div_d = pend_div_q;
    pend_hi_d  = pend_hi_q;
    pend_d     = pend_q;
    upd_ack_d  = 1'b0;
    cfg_err_d  = 1'b0;
    if (apply) begin
      act_div_d = pend_div_q;
      act_hi_d  = pend_hi_q;
      pend_d    = 1'b0;
      upd_ack_d = 1'b1;
    end
    if (load && !load_ok) begin
      cfg_err_d = 1'b1;
    end
    if (load_ok) begin
      pend_div_d = cfg_div;
      pend_hi_d  = cfg_hi;
      pend_d     = 1'b1;
    end
  end

  // Counter: held at zero outside RUN, wraps at the boundary so every
  // restart or new configuration begins a fresh period
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || boundary) begin
      count_d = '0;
    end
  end

  // Output decode on next-cycle values so clk_out and tick come straight
  // from flops yet line up with the count they describe
  always_comb begin
    lo_d      = {1'b0, act_div_d} + (WIDTH+1)'(1) - {1'b0, act_hi_d};
    clk_out_d = (state_d == ST_RUN) && ({1'b0, count_d} >= lo_d);
    tick_d    = (state_d == ST_RUN) && (count_d == act_div_d);
  end

  // Datapath and output registers, all cleared asynchronously
  always_ff @(posedge clk_50MHz or negedge clr) begin
    if (!clr) begin
      count_q    <= '0;
      act_div_q  <= DEF_DIV;
      act_hi_q   <= DEF_HI;
      pend_div_q <= '0;
      pend_hi_q  <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      upd_ack_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      act_div_q  <= act_div_d;
      act_hi_q   <= act_hi_d;
      pend_div_q <= pend_div_d;
      pend_hi_q  <= pend_hi_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      upd_ack_q  <= upd_ack_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign upd_ack = upd_ack_q;
  assign cfg_err = cfg_err_q;
  assign busy    = pend_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Testbench for freq_div_prog: directed scenarios plus random traffic, with a
// period/high-time reference model feeding an expectation queue that a
// separate monitor drains once per cycle.
module tb_freq_div_prog;

  localparam int W = 8;
  localparam int DDIV = 9;
  localparam int DHI = 5;

  logic         clk;
  logic         clr;
  logic         en;
  logic         load;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_hi;
  logic         clk_out;
  logic         tick;
  logic         upd_ack;
  logic         cfg_err;
  logic         busy;

  freq_div_prog #(
    .WIDTH  (W),
    .DEF_DIV(W'(DDIV)),
    .DEF_HI (W'(DHI))
  ) dut (
    .clk_50MHz(clk),
    .clr      (clr),
    .en       (en),
    .load     (load),
    .cfg_div  (cfg_div),
    .cfg_hi   (cfg_hi),
    .clk_out  (clk_out),
    .tick     (tick),
    .upd_ack  (upd_ack),
    .cfg_err  (cfg_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {clk_out, tick, upd_ack, cfg_err, busy}
  typedef logic [4:0] obs_t;

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_got;
  int   compared;
  int   mismatched;

  // Reference model: period length P, high time H, position inside period
  bit m_run;
  int m_pos;
  int m_P;
  int m_H;
  bit m_pend;
  int m_pP;
  int m_pH;

  task automatic model_reset();
    m_run  = 1'b0;
    m_pos  = 0;
    m_P    = DDIV + 1;
    m_H    = DHI;
    m_pend = 1'b0;
    m_pP   = 0;
    m_pH   = 0;
  endtask

  // Advance the model by one clock given this cycle's inputs and return
  // what the outputs must show during the following cycle.
  task automatic model_cycle(input bit c, input bit e, input bit l,
                             input int d, input int h, output obs_t o);
    bit ok;
    bit err;
    bit last;
    bit apply;
    int npos;
    if (!c) begin
      model_reset();
      o = '0;
      return;
    end
    ok    = l && (d != 0) && (h <= d + 1);
    err   = l && !ok;
    last  = m_run && (m_pos == m_P - 1);
    apply = m_pend && (!m_run || last);
    npos  = (m_run && e) ? (m_pos + 1) % m_P : 0;
    if (apply) begin
      m_P    = m_pP;
      m_H    = m_pH;
      m_pend = 1'b0;
    end
    if (ok) begin
      m_pP   = d + 1;
      m_pH   = h;
      m_pend = 1'b1;
    end
    m_run = e;
    m_pos = npos;
    o = {m_run && (m_pos >= m_P - m_H), m_run && (m_pos == m_P - 1),
         apply, err, m_pend};
  endtask

  task automatic step(input bit e, input bit l, input int d, input int h);
    obs_t o;
    @(negedge clk);
    en      = e;
    load    = l;
    cfg_div = W'(d);
    cfg_hi  = W'(h);
    model_cycle(clr, e, l, d, h, o);
    exp_q.push_back(o);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  // Drop clr between edges and check outputs clear without a clock edge
  task automatic do_reset();
    obs_t g;
    obs_t o;
    @(negedge clk);
    #2;
    clr = 1'b0;
    exp_q.delete();
    #1;
    g = {clk_out, tick, upd_ack, cfg_err, busy};
    compared++;
    if (g !== 5'b0) begin
      mismatched++;
      $display("FAIL async_reset t=%0t got=%b required=00000", $time, g);
    end
    model_reset();
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    clr  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    model_cycle(1'b1, 1'b0, 1'b0, 0, 0, o);
    exp_q.push_back(o);
  endtask

  // Step until the model sits in the last cycle of a running period
  task automatic wait_boundary(input int max_cycles);
    int n;
    n = 0;
    while (!(m_run && m_pos == m_P - 1) && n < max_cycles) begin
      step(1'b1, 1'b0, 0, 0);
      n++;
    end
    compared++;
    if (!(m_run && m_pos == m_P - 1)) begin
      mismatched++;
      $display("FAIL boundary_timeout waited=%0d cycles required<%0d", n, max_cycles);
    end
  endtask

  // Monitor: one expectation per clock, compared shortly after the edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {clk_out, tick, upd_ack, cfg_err, busy};
      compared++;
      if (mon_got !== mon_exp) begin
        mismatched++;
        $display("FAIL cycle_check t=%0t got=%b required=%b (clk_out,tick,upd_ack,cfg_err,busy)",
                 $time, mon_got, mon_exp);
      end
    end
  end

  initial begin
    bit e;
    bit l;
    int d;
    int h;
    compared   = 0;
    mismatched = 0;
    clr     = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    cfg_div = '0;
    cfg_hi  = '0;
    model_reset();

    do_reset();

    // Default 10-cycle period: 5 low, 5 high
    run_cycles(25);

    // Mid-period reconfiguration to a period of 4 with one high cycle
    step(1'b1, 1'b1, 3, 1);
    run_cycles(15);

    // Rejected loads leave everything as it was
    step(1'b1, 1'b1, 0, 2);
    run_cycles(3);
    step(1'b1, 1'b1, 3, 5);
    run_cycles(6);

    // Load landing exactly on a boundary while another is pending
    step(1'b1, 1'b1, 5, 2);
    wait_boundary(20);
    step(1'b1, 1'b1, 7, 4);
    run_cycles(20);

    // Constant-low and constant-high extremes
    step(1'b1, 1'b1, 4, 0);
    run_cycles(15);
    step(1'b1, 1'b1, 4, 5);
    run_cycles(15);

    // Divide by two
    step(1'b1, 1'b1, 1, 1);
    run_cycles(10);

    // Drop en mid-period, reconfigure while idle, restart
    step(1'b1, 1'b1, 5, 3);
    run_cycles(9);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 6, 2);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 0, 0);
    run_cycles(16);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      e = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 9) == 0);
      d = $urandom_range(0, 7);
      h = $urandom_range(0, d + 2);
      step(e, l, d, h);
    end

    // Reset while a configuration is pending; defaults must return
    step(1'b1, 1'b1, 2, 1);
    step(1'b1, 1'b0, 0, 0);
    do_reset();
    run_cycles(25);

    @(posedge clk);
    #4;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
